uart_recv: RTL and testbench
============================

Name: uart_recv

Overview:
- Serial UART receiver for the host link: 8N1 frames, LSB first, idle-high line.
- Oversamples asynchronous RXD on a divided enable pulse from the shared clock divider.
- Presents each received byte in a one-entry holding register with a ready/ack handshake to the command parser.
- Counterpart of the existing uart_send transmitter; line format matches it bit for bit.

Parameters:
- DATA_BITS, 8, payload bits per frame. Only 8 is supported for link compatibility.
- OVERSAMPLE, 16, UART_CLK_OS pulses per bit time. Must be a power of two, 8 or more.

Ports:
- CLK  in  1  System clock; all state on its rising edge.
- RST  in  1  Asynchronous, active-high reset.
- UART_CLK_OS  in  1  Single-CLK-cycle enable pulse at OVERSAMPLE × baud rate.
- RXD  in  1  Serial data in; asynchronous to CLK; idle high.
- DATA  out  8  Last accepted byte.
- DATA_READY  out  1  Level signal: DATA holds an unconsumed byte.
- DATA_ACK  in  1  Consumer pulse; clears DATA_READY.
- FRAME_ERR  out  1  One-CLK pulse: stop bit sampled low.
- OVERRUN  out  1  One-CLK pulse: good frame arrived while the holding register was still full.
- BUSY  out  1  High in any state other than IDLE.

Behaviour:
- **Reset values:** RST asserted asynchronously forces state IDLE, counters 0, synchronizer flops 1, DATA=0, DATA_READY=0, FRAME_ERR=0, OVERRUN=0, BUSY=0. Reset mid-frame discards the partial byte; no error pulse is generated.
- **Input synchronizer:** RXD passes through 2 flops (rx_s). Start detect is a falling edge of rx_s (previous 1, current 0), evaluated every CLK cycle.
- **Tick counter (tick, 0..OVERSAMPLE-1):**
  - Advances only on UART_CLK_OS.
  - Cleared to 0 on start detect.
  - Wraps at OVERSAMPLE-1, which ends the bit.
- **Bit decision:** rx_s is sampled at ticks M-1, M and M+1, where M = OVERSAMPLE/2. The bit value is the 2-of-3 majority, decided on the M+1 tick.
- **State IDLE:** on start detect, go to START.
- **State START:**
  - Majority 1 at the decision point: false start; return to IDLE with no output.
  - Majority 0: continue; at the tick wrap, go to DATA with bit index = 0.
- **State DATA:**
  - At the decision point, write the bit into shift register position [index] (LSB first).
  - At the tick wrap: if index = 7, go to STOP; otherwise increment index.
- **State STOP:**
  - Majority 1 at the decision point: good frame. Return to IDLE on that same tick (half-bit early, to absorb baud mismatch).
  - Majority 0: assert FRAME_ERR for 1 cycle, discard the byte, return to IDLE.
  - A new start needs a falling edge, so a stuck-low line never retriggers.
- **Delivery of a good frame (the cycle after the deciding tick):**
  - DATA_READY=0, or DATA_ACK=1 in the same cycle: load DATA; DATA_READY=1.
  - DATA_READY=1 and DATA_ACK=0: keep the old DATA, drop the new byte, pulse OVERRUN for 1 cycle.
- **Handshake:** DATA_ACK while DATA_READY=0 has no effect. DATA is stable whenever DATA_READY=1.
- **Latency:** DATA_READY rises exactly 1 CLK after the UART_CLK_OS pulse at stop-bit tick M+1.
- **UART_CLK_OS held high continuously:** legal; the block behaves identically with one tick per CLK.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding: IDLE, START, DATA, STOP;
  - START_BIT = 0 and STOP_BIT = 1;
  - default OVERSAMPLE;
  - the 8N1 frame length of 10.
- Sub-module uart_rx_sync holds the 2-flop synchronizer plus the falling-edge detector.
- Reset value 1 on both synchronizer flops, so reset release does not produce a false edge.

Test Plan:
- **Good frame:** reset, then send 0xA5 with UART_CLK_OS=1 every 4 CLK. Expect DATA=0xA5 and DATA_READY=1 one CLK after stop tick 9; FRAME_ERR and OVERRUN stay 0. Then DATA_ACK -> DATA_READY=0 the next cycle.
- **False start:** a 5-tick low glitch on RXD -> BUSY returns to 0 at tick 9; no DATA_READY and no error pulse.
- **Framing error:** send 0x3C with the stop bit low -> FRAME_ERR pulses 1 cycle; DATA_READY stays 0. Line held low afterwards -> no new frame until RXD goes high then low.
- **Overrun and simultaneous ack:**
  - Send 0x11 with no ack, then 0x22 -> OVERRUN pulses; DATA stays 0x11.
  - Repeat with DATA_ACK in the delivery cycle -> DATA=0x22, DATA_READY stays 1, no OVERRUN.
- **Noise rejection and baud tolerance:** inject a single-tick inverted sample at tick 8 of bit 3 while sending 0x00 -> DATA=0x00. Send 0x55 and 0xFF with bit period skewed ±3% -> both received correctly.
- **Reset mid-frame:** assert RST asynchronously mid bit 4 -> all outputs 0 immediately. Send 0x81 after release -> DATA=0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the host-link UART receiver: FSM state encoding,
// 8N1 line-level constants, default oversampling ratio and the 2-of-3
// majority vote used for every bit decision.
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   localparam logic START_BIT      = 1'b0;
   localparam logic STOP_BIT       = 1'b1;
   localparam int   OVERSAMPLE_DEF = 16;
   // start + 8 data + stop
   localparam int   FRAME_BITS     = 10;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detector on the synchronized value.
//   clk   in   system clock
//   rst   in   asynchronous, active-high reset
//   rxd   in   raw serial input (asynchronous, idle high)
//   rx_s  out  synchronized line value
//   fall  out  high for one cycle when rx_s goes 1 -> 0
// -----------------------------------------------------------------------------
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rxd,
   output logic rx_s,
   output logic fall
);

   logic meta;
   logic rx_d;

   // All three flops reset to the idle line level so that releasing reset
   // never looks like a start-bit edge.
   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour; blocking here would
   // collapse the synchronizer chain into a single stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         meta <= rxd;
         rx_s <= meta;
         rx_d <= rx_s;
      end
   end

   assign fall = rx_d & ~rx_s;

endmodule

// File: rtl/uart_recv.sv
// -----------------------------------------------------------------------------
// uart_recv
// 8N1 UART receiver (LSB first, idle-high line) with a one-entry holding
// register and ready/ack handshake towards the command parser.
//   CLK          in   system clock
//   RST          in   asynchronous, active-high reset
//   UART_CLK_OS  in   one-cycle enable at OVERSAMPLE x baud (may be held high)
//   RXD          in   serial data, asynchronous to CLK
//   DATA         out  last accepted byte, stable while DATA_READY is high
//   DATA_READY   out  DATA holds an unconsumed byte
//   DATA_ACK     in   consumer acknowledge, clears DATA_READY
//   FRAME_ERR    out  one-cycle pulse: stop bit sampled low
//   OVERRUN      out  one-cycle pulse: good frame dropped, register still full
//   BUSY         out  receiver is not idle
// -----------------------------------------------------------------------------
module uart_recv
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 UART_CLK_OS,
   input  logic                 RXD,
   output logic [DATA_BITS-1:0] DATA,
   output logic                 DATA_READY,
   input  logic                 DATA_ACK,
   output logic                 FRAME_ERR,
   output logic                 OVERRUN,
   output logic                 BUSY
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int IW = $clog2(DATA_BITS);

   // Three samples centred on mid-bit; the vote is taken on the last one.
   localparam logic [TW-1:0] TICK_LO  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] TICK_HI  = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   state_t               state;
   logic [TW-1:0]        tick;
   logic [IW-1:0]        idx;
   logic [1:0]           samp;
   logic [DATA_BITS-1:0] shreg;
   logic                 rx_s;
   logic                 fall;
   logic                 bit_val;

   uart_rx_sync u_sync (
      .clk  (CLK),
      .rst  (RST),
      .rxd  (RXD),
      .rx_s (rx_s),
      .fall (fall)
   );

   // Samples at TICK_LO and TICK_MID are held in samp; the third is the live
   // rx_s at TICK_HI, which is when bit_val is consumed.
   assign bit_val = majority3(samp[0], samp[1], rx_s);

   // NOTE: reset is asynchronous, so it is in the sensitivity list and is
   // the first branch tested; every register here, including the shift
   // register, gets a defined reset value.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= ST_IDLE;
         tick       <= '0;
         idx        <= '0;
         samp       <= '0;
         shreg      <= '0;
         DATA       <= '0;
         DATA_READY <= 1'b0;
         FRAME_ERR  <= 1'b0;
         OVERRUN    <= 1'b0;
         BUSY       <= 1'b0;
      end else begin
         FRAME_ERR <= 1'b0;
         OVERRUN   <= 1'b0;

         if (DATA_READY && DATA_ACK) begin
            DATA_READY <= 1'b0;
         end

         // The tick counter free-runs on the enable; OVERSAMPLE is a power of
         // two so the natural wrap is the end of the bit.
         if (UART_CLK_OS) begin
            tick <= tick + 1'b1;
            if (tick == TICK_LO) begin
               samp[0] <= rx_s;
            end
            if (tick == TICK_MID) begin
               samp[1] <= rx_s;
            end
         end

         case (state)
            ST_IDLE: begin
               // Overrides the tick increment above: bit timing restarts at
               // the detected edge.
               if (fall) begin
                  state <= ST_START;
                  tick  <= '0;
                  BUSY  <= 1'b1;
               end
            end

            ST_START: begin
               if (UART_CLK_OS) begin
                  if (tick == TICK_HI && bit_val != START_BIT) begin
                     // Glitch shorter than half a bit: not a real start.
                     state <= ST_IDLE;
                     BUSY  <= 1'b0;
                  end else if (tick == TICK_END) begin
                     state <= ST_DATA;
                     idx   <= '0;
                  end
               end
            end

            ST_DATA: begin
               if (UART_CLK_OS) begin
                  if (tick == TICK_HI) begin
                     shreg[idx] <= bit_val;
                  end
                  if (tick == TICK_END) begin
                     if (idx == IDX_LAST) begin
                        state <= ST_STOP;
                     end else begin
                        idx <= idx + 1'b1;
                     end
                  end
               end
            end

            ST_STOP: begin
               // Leave at mid stop bit so a slightly fast sender's next start
               // edge is not missed.
               if (UART_CLK_OS && tick == TICK_HI) begin
                  state <= ST_IDLE;
                  BUSY  <= 1'b0;
                  if (bit_val == STOP_BIT) begin
                     // An ack in this same cycle frees the register for the
                     // new byte instead of reporting an overrun.
                     if (!DATA_READY || DATA_ACK) begin
                        DATA       <= shreg;
                        DATA_READY <= 1'b1;
                     end else begin
                        OVERRUN <= 1'b1;
                     end
                  end else begin
                     FRAME_ERR <= 1'b1;
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_recv.sv
// -----------------------------------------------------------------------------
// tb_uart_recv
// Self-checking bench for uart_recv. Frames are driven cycle by cycle on RXD;
// UART_CLK_OS pulses every 4 CLK (or is held high). Each good frame pushes
// its byte and the expected enable-pulse count of its delivery to a
// scoreboard; a negedge monitor records every delivery, which the scenario
// tasks pop and compare.
// -----------------------------------------------------------------------------
module tb_uart_recv;
   import uart_pkg::*;

   localparam int OS      = OVERSAMPLE_DEF;
   localparam int OS_DIV  = 4;
   localparam int BIT_CYC = OS * OS_DIV;
   // Enable pulses after the start-detect edge up to and including the one
   // at stop-bit tick M+1: stop bit index 9, tick M+1, counted from 1.
   localparam int DECIDE_PULSE = (FRAME_BITS - 1) * OS + (OS / 2 + 1) + 1;
   // RXD cycles within a bit (at OS_DIV CLK per tick) that reach the sampler
   // exactly at the tick-M sample and at no other sample.
   localparam int GLITCH_LO = OS_DIV * (OS / 2) + 1;
   localparam int GLITCH_HI = OS_DIV * (OS / 2) + OS_DIV;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       UART_CLK_OS = 1'b0;
   logic       RXD = 1'b1;
   logic       DATA_ACK = 1'b0;
   logic [7:0] DATA;
   logic       DATA_READY;
   logic       FRAME_ERR;
   logic       OVERRUN;
   logic       BUSY;

   uart_recv #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .UART_CLK_OS (UART_CLK_OS),
      .RXD         (RXD),
      .DATA        (DATA),
      .DATA_READY  (DATA_READY),
      .DATA_ACK    (DATA_ACK),
      .FRAME_ERR   (FRAME_ERR),
      .OVERRUN     (OVERRUN),
      .BUSY        (BUSY)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- enable pulse / ack generator ----------------
   logic os_hold    = 1'b0;
   logic ack_req    = 1'b0;
   int   ack_target = -1;
   int   os_count   = 0;
   logic last_os    = 1'b0;

   always @(posedge CLK) begin
      os_count <= os_count + (UART_CLK_OS ? 1 : 0);
      last_os  <= UART_CLK_OS;
   end

   initial begin
      int phase;
      phase = 0;
      forever begin
         @(posedge CLK);
         #2;
         phase       = (phase + 1) % OS_DIV;
         UART_CLK_OS = os_hold || (phase == 0);
         DATA_ACK    = ack_req || (UART_CLK_OS && (ack_target == os_count + 1));
      end
   end

   // ---------------- output monitor ----------------
   logic [7:0] got_data[$];
   int         got_os[$];
   logic       got_last[$];
   int         ferr_cnt = 0;
   int         ovr_cnt  = 0;
   int         wide_cnt = 0;
   int         drop_cnt = 0;
   logic       p_ready  = 1'b0;
   logic       p_ferr   = 1'b0;
   logic       p_ovr    = 1'b0;
   logic [7:0] p_data   = 8'h00;

   always @(negedge CLK) begin
      if (DATA_READY && (!p_ready || DATA !== p_data)) begin
         got_data.push_back(DATA);
         got_os.push_back(os_count);
         got_last.push_back(last_os);
      end
      if (p_ready && !DATA_READY) drop_cnt <= drop_cnt + 1;
      if (FRAME_ERR) ferr_cnt <= ferr_cnt + 1;
      if (OVERRUN)   ovr_cnt  <= ovr_cnt + 1;
      wide_cnt <= wide_cnt + ((FRAME_ERR && p_ferr) ? 1 : 0) + ((OVERRUN && p_ovr) ? 1 : 0);
      p_ready <= DATA_READY;
      p_ferr  <= FRAME_ERR;
      p_ovr   <= OVERRUN;
      p_data  <= DATA;
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [7:0] data;
      int         os_target;
   } exp_t;

   exp_t exp_q[$];
   int   got_rd   = 0;
   int   start_os = 0;

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Drives one frame. glitch_bit inverts RXD around that bit's tick-M sample;
   // abort_bit asserts RST halfway through that bit and returns.
   task automatic send_frame(input logic [7:0] b, input int cyc, input logic stop_val,
                             input int glitch_bit, input int abort_bit, input logic ack_at_decide);
      logic [9:0] fr;
      fr = {stop_val, b, START_BIT};
      @(posedge CLK);
      #1;
      for (int i = 0; i < FRAME_BITS; i++) begin
         for (int c = 0; c < cyc; c++) begin
            if (i == abort_bit && c == cyc / 2) begin
               RST = 1'b1;
               return;
            end
            RXD = fr[i] ^ (i == glitch_bit && c >= GLITCH_LO && c <= GLITCH_HI);
            @(posedge CLK);
            #1;
            // Third edge after the start bit is driven: start detect lands here.
            if (i == 0 && c == 2) begin
               start_os = os_count;
               if (ack_at_decide) ack_target = os_count + DECIDE_PULSE;
            end
         end
      end
   endtask

   task automatic expect_byte(input logic [7:0] b);
      exp_t e;
      e.data      = b;
      e.os_target = start_os + DECIDE_PULSE;
      exp_q.push_back(e);
   endtask

   task automatic wait_delivery(input string name);
      exp_t e;
      int   t;
      t = 0;
      while (got_data.size() <= got_rd && t < 3000) begin
         @(negedge CLK);
         t++;
      end
      n_cmp++;
      if (got_data.size() <= got_rd || exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL %s: delivered=%0d expected_pending=%0d (no matching delivery)",
                  name, got_data.size() - got_rd, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         if (got_data[got_rd] !== e.data) begin
            n_bad++;
            $display("FAIL %s data: got %h expected %h", name, got_data[got_rd], e.data);
         end
         n_cmp++;
         if (got_os[got_rd] !== e.os_target || got_last[got_rd] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s latency: ready at pulse %0d (pulse edge %b) expected pulse %0d (pulse edge 1)",
                     name, got_os[got_rd] - start_os, got_last[got_rd], DECIDE_PULSE);
         end
         got_rd++;
      end
   endtask

   task automatic do_ack();
      @(posedge CLK);
      #1;
      ack_req = 1'b1;
      @(posedge CLK);
      #1;
      ack_req = 1'b0;
   endtask

   task automatic cmp1(input string name, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic cmp_int(input string name, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle(3);
      @(negedge CLK);
      cmp_int("reset DATA", int'(DATA), 0);
      cmp1("reset DATA_READY", DATA_READY, 1'b0);
      cmp1("reset FRAME_ERR", FRAME_ERR, 1'b0);
      cmp1("reset OVERRUN", OVERRUN, 1'b0);
      cmp1("reset BUSY", BUSY, 1'b0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      idle(20);
      @(negedge CLK);
      cmp1("no start after reset release", BUSY, 1'b0);
   endtask

   task automatic test_good_frame();
      int f0, o0;
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      send_frame(8'hA5, BIT_CYC, 1'b1, -1, -1, 1'b0);
      expect_byte(8'hA5);
      wait_delivery("good_a5");
      @(negedge CLK);
      cmp1("good DATA_READY", DATA_READY, 1'b1);
      cmp1("good BUSY idle", BUSY, 1'b0);
      cmp_int("good no error pulses", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
      do_ack();
      @(negedge CLK);
      cmp1("ack clears ready", DATA_READY, 1'b0);
   endtask

   task automatic test_false_start();
      int f0, o0, g0;
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      g0 = got_data.size();
      @(posedge CLK);
      #1;
      RXD = 1'b0;
      idle(5 * OS_DIV);
      RXD = 1'b1;
      idle(10);
      @(negedge CLK);
      cmp1("false start BUSY during glitch", BUSY, 1'b1);
      idle(50);
      @(negedge CLK);
      cmp1("false start BUSY released", BUSY, 1'b0);
      cmp_int("false start no output", (ferr_cnt - f0) + (ovr_cnt - o0) + (got_data.size() - g0), 0);
      cmp1("false start DATA_READY", DATA_READY, 1'b0);
   endtask

   task automatic test_frame_error();
      int f0, g0, busy_seen;
      f0 = ferr_cnt;
      g0 = got_data.size();
      send_frame(8'h3C, BIT_CYC, 1'b0, -1, -1, 1'b0);
      @(negedge CLK);
      cmp_int("frame error pulse count", ferr_cnt - f0, 1);
      cmp1("frame error DATA_READY", DATA_READY, 1'b0);
      cmp_int("frame error no delivery", got_data.size() - g0, 0);
      busy_seen = 0;
      for (int i = 0; i < 4 * BIT_CYC; i++) begin
         @(negedge CLK);
         if (BUSY) busy_seen++;
      end
      cmp_int("stuck-low line never retriggers", busy_seen, 0);
      @(posedge CLK);
      #1;
      RXD = 1'b1;
      idle(BIT_CYC);
      send_frame(8'h5A, BIT_CYC, 1'b1, -1, -1, 1'b0);
      expect_byte(8'h5A);
      wait_delivery("after_ferr_5a");
      do_ack();
   endtask

   task automatic test_overrun();
      int o0, d0;
      send_frame(8'h11, BIT_CYC, 1'b1, -1, -1, 1'b0);
      expect_byte(8'h11);
      wait_delivery("ovr_first_11");
      o0 = ovr_cnt;
      send_frame(8'h22, BIT_CYC, 1'b1, -1, -1, 1'b0);
      idle(4);
      @(negedge CLK);
      cmp_int("overrun pulse count", ovr_cnt - o0, 1);
      cmp_int("overrun keeps DATA", int'(DATA), 8'h11);
      cmp1("overrun keeps DATA_READY", DATA_READY, 1'b1);
      cmp_int("overrun no new delivery", got_data.size() - got_rd, 0);
      // Same situation, but acknowledged in the delivery cycle.
      d0 = drop_cnt;
      send_frame(8'h22, BIT_CYC, 1'b1, -1, -1, 1'b1);
      expect_byte(8'h22);
      wait_delivery("ack_same_cycle_22");
      ack_target = -1;
      @(negedge CLK);
      cmp1("same-cycle ack DATA_READY", DATA_READY, 1'b1);
      cmp_int("same-cycle ack ready never dropped", drop_cnt - d0, 0);
      cmp_int("same-cycle ack no overrun", ovr_cnt - o0, 1);
      do_ack();
   endtask

   task automatic test_noise_baud();
      int f0;
      f0 = ferr_cnt;
      idle(BIT_CYC);
      send_frame(8'h00, BIT_CYC, 1'b1, 4, -1, 1'b0);
      expect_byte(8'h00);
      wait_delivery("noise_00");
      do_ack();
      idle(BIT_CYC);
      send_frame(8'h55, BIT_CYC - 2, 1'b1, -1, -1, 1'b0);
      expect_byte(8'h55);
      wait_delivery("fast_55");
      do_ack();
      idle(BIT_CYC);
      send_frame(8'hFF, BIT_CYC + 2, 1'b1, -1, -1, 1'b0);
      expect_byte(8'hFF);
      wait_delivery("slow_ff");
      do_ack();
      cmp_int("noise/baud no frame errors", ferr_cnt - f0, 0);
   endtask

   task automatic test_os_held();
      @(posedge CLK);
      #1;
      os_hold = 1'b1;
      idle(OS);
      send_frame(8'h96, OS, 1'b1, -1, -1, 1'b0);
      expect_byte(8'h96);
      wait_delivery("os_held_96");
      do_ack();
      os_hold = 1'b0;
      idle(OS);
   endtask

   task automatic test_reset_midframe();
      send_frame(8'h7E, BIT_CYC, 1'b1, -1, -1, 1'b0);
      expect_byte(8'h7E);
      wait_delivery("pre_reset_7e");
      send_frame(8'h33, BIT_CYC, 1'b1, -1, 5, 1'b0);
      #1;
      cmp_int("async reset DATA", int'(DATA), 0);
      cmp1("async reset DATA_READY", DATA_READY, 1'b0);
      cmp1("async reset BUSY", BUSY, 1'b0);
      cmp1("async reset FRAME_ERR", FRAME_ERR, 1'b0);
      cmp1("async reset OVERRUN", OVERRUN, 1'b0);
      RXD = 1'b1;
      idle(3);
      RST = 1'b0;
      idle(20);
      send_frame(8'h81, BIT_CYC, 1'b1, -1, -1, 1'b0);
      expect_byte(8'h81);
      wait_delivery("post_reset_81");
      do_ack();
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_false_start();
      test_frame_error();
      test_overrun();
      test_noise_baud();
      test_os_held();
      test_reset_midframe();
      idle(10);
      cmp_int("pulses wider than one cycle", wide_cnt, 0);
      cmp_int("undelivered expected bytes", exp_q.size(), 0);
      cmp_int("unexpected deliveries", got_data.size() - got_rd, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

endmodule
